// File: rtl/phase_sweep_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_sweep_controller_pkg
// Description : Shared mode codes, FSM state encoding and settle default for
//               the phase sweep controller and its step calculator.
// Revision    : 1.0
// ============================================================================
package phase_sweep_controller_pkg;

    // Sweep modes as presented on i_cfg_mode
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_FIXED  = 2'd3;

    // Two accumulator recalculation periods of 8 cycles each
    localparam int SETTLE_DEFAULT = 16;

    // One-hot controller states
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ARM  = 3'b010,
        S_RUN  = 3'b100
    } state_t;

endpackage
`default_nettype wire

// File: rtl/phase_sweep_controller_step_calc.sv
`default_nettype none
// ============================================================================
// Module      : sweep_step_calc
// Description : Combinational next-frequency calculation for one sweep step.
//               Produces the step toward the current direction, the step back
//               toward the opposite bound (triangle turn) and an end-of-leg
//               flag when the current frequency already sits on its bound.
// Revision    : 1.0
// ============================================================================
module sweep_step_calc #(
    parameter int FREQ_W = 12
) (
    input  logic [FREQ_W-1:0] i_f,
    input  logic [FREQ_W-1:0] i_step,
    input  logic [FREQ_W-1:0] i_lo,
    input  logic [FREQ_W-1:0] i_hi,
    input  logic              i_dir_up,
    output logic [FREQ_W-1:0] o_f_next,
    output logic [FREQ_W-1:0] o_f_turn,
    output logic              o_end_of_leg
);

    logic [FREQ_W:0]   w_sum;
    logic [FREQ_W:0]   w_diff;
    logic [FREQ_W-1:0] w_f_up;
    logic [FREQ_W-1:0] w_f_dn;

    // Saturating add toward hi and subtract toward lo; the extra bit keeps carry/borrow
    always_comb begin
        w_sum        = {1'b0, i_f} + {1'b0, i_step};
        w_diff       = {1'b0, i_f} - {1'b0, i_step};
        w_f_up       = (w_sum > {1'b0, i_hi}) ? i_hi : w_sum[FREQ_W-1:0];
        w_f_dn       = (w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] < i_lo)) ? i_lo : w_diff[FREQ_W-1:0];
        o_end_of_leg = i_dir_up ? (i_f == i_hi) : (i_f == i_lo);
        o_f_next     = i_dir_up ? w_f_up : w_f_dn;
        o_f_turn     = i_dir_up ? w_f_dn : w_f_up;
    end

endmodule
`default_nettype wire

// File: rtl/phase_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : phase_sweep_controller
// Description : Drives frequency/enable/offset of a phase accumulator to run
//               single, sawtooth, triangle or fixed-tone frequency sweeps with
//               a programmable dwell per step and a settle period before run.
// Revision    : 1.0
// ============================================================================
module phase_sweep_controller
    import phase_sweep_controller_pkg::*;
#(
    parameter int FREQ_W  = 12,
    parameter int DWELL_W = 24,
    parameter int PHASE_W = 24,
    parameter int F_MIN   = 3,
    parameter int SETTLE  = SETTLE_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [FREQ_W-1:0]  i_cfg_f_start,
    input  logic [FREQ_W-1:0]  i_cfg_f_stop,
    input  logic [FREQ_W-1:0]  i_cfg_f_step,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic [1:0]         i_cfg_mode,
    input  logic [PHASE_W-1:0] i_cfg_offset,
    input  logic               i_start,
    input  logic               i_stop,
    output logic [FREQ_W-1:0]  o_frequency,
    output logic [PHASE_W-1:0] o_offset,
    output logic               o_enable,
    output logic               o_busy,
    output logic               o_step_strobe,
    output logic               o_done
);

    localparam logic [FREQ_W-1:0]  c_f_min  = FREQ_W'(F_MIN);
    localparam logic [DWELL_W-1:0] c_settle = DWELL_W'(SETTLE);
    localparam logic [DWELL_W-1:0] c_one    = DWELL_W'(1);

    state_t             r_state_q, w_state_d;
    logic [FREQ_W-1:0]  r_start_q, w_start_d, r_stop_q, w_stop_d, r_step_q, w_step_d;
    logic [DWELL_W-1:0] r_dwell_q, w_dwell_d, r_cnt_q, w_cnt_d;
    logic [1:0]         r_mode_q, w_mode_d;
    logic [PHASE_W-1:0] r_cfg_off_q, w_cfg_off_d, r_off_q, w_off_d;
    logic [FREQ_W-1:0]  r_freq_q, w_freq_d;
    logic               r_enable_q, w_enable_d;
    logic               r_strobe_q, w_strobe_d;
    logic               r_done_q, w_done_d;
    logic               r_dir_up_q, w_dir_up_d;
    logic               w_cfg_fire;
    logic [FREQ_W-1:0]  w_lo, w_hi, w_f_next, w_f_turn;
    logic               w_end_of_leg;

    assign w_cfg_fire = i_cfg_valid && (r_state_q == S_IDLE);
    assign w_lo       = (r_start_q < r_stop_q) ? r_start_q : r_stop_q;
    assign w_hi       = (r_start_q < r_stop_q) ? r_stop_q : r_start_q;

    sweep_step_calc #(
        .FREQ_W (FREQ_W)
    ) u_step_calc (
        .i_f          (r_freq_q),
        .i_step       (r_step_q),
        .i_lo         (w_lo),
        .i_hi         (w_hi),
        .i_dir_up     (r_dir_up_q),
        .o_f_next     (w_f_next),
        .o_f_turn     (w_f_turn),
        .o_end_of_leg (w_end_of_leg)
    );

    // Clamp and latch a config beat; a zero step degenerates to a fixed tone
    always_comb begin
        w_start_d   = r_start_q;
        w_stop_d    = r_stop_q;
        w_step_d    = r_step_q;
        w_dwell_d   = r_dwell_q;
        w_mode_d    = r_mode_q;
        w_cfg_off_d = r_cfg_off_q;
        if (w_cfg_fire) begin
            w_start_d   = (i_cfg_f_start < c_f_min) ? c_f_min : i_cfg_f_start;
            w_stop_d    = (i_cfg_f_stop < c_f_min) ? c_f_min : i_cfg_f_stop;
            w_step_d    = i_cfg_f_step;
            w_dwell_d   = (i_cfg_dwell < c_settle) ? c_settle : i_cfg_dwell;
            w_mode_d    = (i_cfg_f_step == '0) ? MODE_FIXED : i_cfg_mode;
            w_cfg_off_d = i_cfg_offset;
        end
    end

    // Sweep FSM: next state, dwell counter and output register inputs
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_freq_d   = r_freq_q;
        w_off_d    = r_off_q;
        w_enable_d = r_enable_q;
        w_dir_up_d = r_dir_up_q;
        w_done_d   = 1'b0;
        w_strobe_d = 1'b0;
        unique case (r_state_q)
            S_IDLE: begin
                // Uses w_*_d so a config beat in the same cycle takes effect
                if (i_start) begin
                    w_state_d  = S_ARM;
                    w_freq_d   = w_start_d;
                    w_off_d    = w_cfg_off_d;
                    w_cnt_d    = c_settle - c_one;
                    w_enable_d = 1'b0;
                    w_dir_up_d = (w_stop_d >= w_start_d);
                end
            end
            S_ARM: begin
                if (r_cnt_q == '0) begin
                    w_state_d  = S_RUN;
                    w_enable_d = 1'b1;
                    w_cnt_d    = r_dwell_q - c_one;
                end else begin
                    w_cnt_d = r_cnt_q - c_one;
                end
            end
            S_RUN: begin
                if (r_mode_q != MODE_FIXED) begin
                    if (r_cnt_q == '0) begin
                        w_cnt_d = r_dwell_q - c_one;
                        if (!w_end_of_leg) begin
                            w_freq_d = w_f_next;
                        end else if (r_mode_q == MODE_SAW) begin
                            w_freq_d = r_start_q;
                        end else if (r_mode_q == MODE_TRI) begin
                            w_freq_d   = w_f_turn;
                            w_dir_up_d = !r_dir_up_q;
                        end else begin
                            w_state_d  = S_IDLE;
                            w_enable_d = 1'b0;
                            w_done_d   = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q - c_one;
                    end
                end
            end
            default: begin
                w_state_d  = S_IDLE;
                w_enable_d = 1'b0;
            end
        endcase
        // Abort wins over everything, including a terminal count this cycle
        if (i_stop && (r_state_q != S_IDLE)) begin
            w_state_d  = S_IDLE;
            w_enable_d = 1'b0;
            w_done_d   = 1'b1;
            w_freq_d   = r_freq_q;
            w_dir_up_d = r_dir_up_q;
        end
        w_strobe_d = (r_state_q == S_RUN) && (w_freq_d != r_freq_q);
    end

    // State, config and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= S_IDLE;
            r_start_q   <= c_f_min;
            r_stop_q    <= c_f_min;
            r_step_q    <= '0;
            r_dwell_q   <= c_settle;
            r_mode_q    <= MODE_SINGLE;
            r_cfg_off_q <= '0;
            r_cnt_q     <= '0;
            r_freq_q    <= c_f_min;
            r_off_q     <= '0;
            r_enable_q  <= 1'b0;
            r_strobe_q  <= 1'b0;
            r_done_q    <= 1'b0;
            r_dir_up_q  <= 1'b1;
        end else begin
            r_state_q   <= w_state_d;
            r_start_q   <= w_start_d;
            r_stop_q    <= w_stop_d;
            r_step_q    <= w_step_d;
            r_dwell_q   <= w_dwell_d;
            r_mode_q    <= w_mode_d;
            r_cfg_off_q <= w_cfg_off_d;
            r_cnt_q     <= w_cnt_d;
            r_freq_q    <= w_freq_d;
            r_off_q     <= w_off_d;
            r_enable_q  <= w_enable_d;
            r_strobe_q  <= w_strobe_d;
            r_done_q    <= w_done_d;
            r_dir_up_q  <= w_dir_up_d;
        end
    end

    assign o_cfg_ready   = (r_state_q == S_IDLE);
    assign o_busy        = (r_state_q != S_IDLE);
    assign o_frequency   = r_freq_q;
    assign o_offset      = r_off_q;
    assign o_enable      = r_enable_q;
    assign o_step_strobe = r_strobe_q;
    assign o_done        = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sweep_controller
// Description : Directed self-checking bench for phase_sweep_controller.
// Revision    : 1.0
// ============================================================================
module tb_phase_sweep_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_f_start, cfg_f_stop, cfg_f_step;
    logic [23:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_offset;
    logic        start, stop;
    logic [11:0] frequency;
    logic [23:0] offset;
    logic        enable, busy, step_strobe, done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    phase_sweep_controller dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_f_start (cfg_f_start),
        .i_cfg_f_stop  (cfg_f_stop),
        .i_cfg_f_step  (cfg_f_step),
        .i_cfg_dwell   (cfg_dwell),
        .i_cfg_mode    (cfg_mode),
        .i_cfg_offset  (cfg_offset),
        .i_start       (start),
        .i_stop        (stop),
        .o_frequency   (frequency),
        .o_offset      (offset),
        .o_enable      (enable),
        .o_busy        (busy),
        .o_step_strobe (step_strobe),
        .o_done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance n rising edges; sample/drive 1 ns after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_cfg(input int f0, input int f1, input int st, input int dw,
                            input int md, input int off);
        cfg_f_start = 12'(f0);
        cfg_f_stop  = 12'(f1);
        cfg_f_step  = 12'(st);
        cfg_dwell   = 24'(dw);
        cfg_mode    = 2'(md);
        cfg_offset  = 24'(off);
    endtask

    task automatic send_cfg(input int f0, input int f1, input int st, input int dw,
                            input int md, input int off);
        load_cfg(f0, f1, st, dw, md, off);
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    // Start, then the 16-cycle settle; afterwards the first RUN cycle is sampled
    task automatic start_and_settle(input int f0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_enable", enable, 0);
        tick(15);
        check("settle_enable_low", enable, 0);
        tick(1);
        check("run_enable", enable, 1);
        check("run_first_freq", frequency, f0);
    endtask

    // One dwell at f_now, then the step to f_next with a strobe
    task automatic leg(input int f_now, input int f_next, input int dwell);
        tick(dwell - 1);
        check("dwell_hold_freq", frequency, f_now);
        check("dwell_hold_strobe", step_strobe, 0);
        tick(1);
        check("step_freq", frequency, f_next);
        check("step_strobe", step_strobe, 1);
        check("step_enable", enable, 1);
    endtask

    task automatic abort_and_check(input int f_hold);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("abort_done", done, 1);
        check("abort_enable", enable, 0);
        check("abort_busy", busy, 0);
        check("abort_freq_hold", frequency, f_hold);
        check("abort_strobe", step_strobe, 0);
        tick(1);
        check("abort_done_clear", done, 0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        load_cfg(0, 0, 0, 0, 0, 0);
        tick(2);
        rst = 1'b0;
        check("rst_ready", cfg_ready, 1);
        check("rst_freq", frequency, 3);
        check("rst_offset", offset, 0);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobe", step_strobe, 0);

        // Single up sweep 100..130 step 10, dwell 20
        send_cfg(100, 130, 10, 20, 0, 24'h123456);
        start_and_settle(100);
        check("single_offset", offset, 24'h123456);
        leg(100, 110, 20);
        leg(110, 120, 20);
        leg(120, 130, 20);
        tick(19);
        check("single_last_hold", frequency, 130);
        check("single_last_enable", enable, 1);
        tick(1);
        check("single_done", done, 1);
        check("single_enable_drop", enable, 0);
        check("single_freq_hold", frequency, 130);
        check("single_end_strobe", step_strobe, 0);
        tick(1);
        check("single_done_pulse", done, 0);

        // Down sweep with clamps; config beat and start share one cycle
        load_cfg(50, 2, 20, 5, 0, 0);
        cfg_valid = 1'b1;
        start_and_settle(50);
        cfg_valid = 1'b0;
        leg(50, 30, 16);
        leg(30, 10, 16);
        leg(10, 3, 16);
        tick(16);
        check("down_done", done, 1);
        check("down_freq", frequency, 3);

        // Sawtooth 10..40 step 15, enable stays high across the reload
        send_cfg(10, 40, 15, 16, 1, 0);
        start_and_settle(10);
        leg(10, 25, 16);
        leg(25, 40, 16);
        leg(40, 10, 16);
        leg(10, 25, 16);
        abort_and_check(25);

        // Triangle 10..30 step 10
        send_cfg(10, 30, 10, 16, 2, 0);
        start_and_settle(10);
        leg(10, 20, 16);
        leg(20, 30, 16);
        leg(30, 20, 16);
        leg(20, 10, 16);
        leg(10, 20, 16);
        leg(20, 30, 16);
        leg(30, 20, 16);
        leg(20, 10, 16);
        abort_and_check(10);

        // Stop on the terminal-count cycle; start while busy is ignored
        send_cfg(100, 130, 10, 20, 0, 0);
        start_and_settle(100);
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_start_ignored_busy", busy, 1);
        check("busy_start_ignored_freq", frequency, 100);
        tick(13);
        check("pre_terminal_freq", frequency, 100);
        abort_and_check(100);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("idle_stop_no_done", done, 0);

        // Zero step becomes a fixed tone that never terminates
        send_cfg(77, 200, 0, 16, 0, 0);
        start_and_settle(77);
        tick(40);
        check("fixed_freq", frequency, 77);
        check("fixed_busy", busy, 1);
        check("fixed_strobe", step_strobe, 0);
        abort_and_check(77);

        // Config ignored while busy, then reset mid-RUN
        send_cfg(200, 300, 50, 16, 1, 24'h0ABCDE);
        start_and_settle(200);
        load_cfg(500, 600, 7, 40, 0, 24'h111111);
        cfg_valid = 1'b1;
        check("run_cfg_ready_low", cfg_ready, 0);
        tick(1);
        cfg_valid = 1'b0;
        abort_and_check(200);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("cfg_kept_freq", frequency, 200);
        check("cfg_kept_offset", offset, 24'h0ABCDE);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrun_rst_freq", frequency, 3);
        check("midrun_rst_offset", offset, 0);
        check("midrun_rst_enable", enable, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_ready", cfg_ready, 1);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_strobe", step_strobe, 0);

        // Reset config: start=stop=F_MIN, one settle-length dwell then done
        start_and_settle(3);
        tick(15);
        check("rstcfg_hold", done, 0);
        tick(1);
        check("rstcfg_done", done, 1);
        check("rstcfg_freq", frequency, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
